// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port responder.
// Contents:
//   CPU_DATA_W / CPU_ADDR_W : default data and address widths
//   state_t                 : responder FSM encoding
//   region_t                : address-decode result (REG_RAM / REG_IO / REG_ERR)
// Optional feature macro: MEM_RESP_MMIO_EN (adds the MMIO states).
package cpu_mem_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_ADDR_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_WR      = 3'd2,
      ST_ERR     = 3'd3,
      ST_RSP     = 3'd4
`ifdef MEM_RESP_MMIO_EN
      ,
      ST_IO      = 3'd5,
      ST_IO_WAIT = 3'd6
`endif
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM = 2'd0,
      REG_IO  = 2'd1,
      REG_ERR = 2'd2
   } region_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder for the memory-port responder.
// Ports:
//   addr   in  ADDR_W  request address
//   ifetch in  1       request is an instruction fetch
//   region out region_t  REG_RAM, REG_IO or REG_ERR
// Optional feature macro: MEM_RESP_MMIO_EN. When undefined the MMIO window
// is not decoded and falls into REG_ERR.
module mem_addr_decode
   import cpu_mem_pkg::*;
#(
   parameter int                ADDR_W    = CPU_ADDR_W,
   parameter int                RAM_AW    = 10,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              ifetch,
   output region_t           region
);

   logic in_ram;

   // Any set bit above the RAM index means the access is outside the RAM,
   // so the low bits are never allowed to alias.
   assign in_ram = ((addr >> RAM_AW) == '0);

`ifdef MEM_RESP_MMIO_EN
   logic in_io;
   // Code is never fetched from the register window.
   assign in_io = (addr >= MMIO_BASE) && !ifetch;

   always_comb begin
      region = REG_ERR;
      if (in_ram)
         region = REG_RAM;
      else if (in_io)
         region = REG_IO;
   end
`else
   logic unused_ifetch;
   assign unused_ifetch = ifetch;

   always_comb begin
      region = REG_ERR;
      if (in_ram)
         region = REG_RAM;
   end
`endif

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder for the multicycle CPU control FSM.
// Accepts one fetch/load/store at a time on a valid/ready handshake, drives
// the block RAM (fixed read latency RD_LAT) or the MMIO window, and returns a
// one-cycle rsp_valid pulse carrying read data or a write acknowledgement.
// Illegal addresses produce rsp_valid with rsp_err and rsp_data = 0.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_write/req_ifetch          store / instruction-fetch qualifiers
//   req_addr/req_wdata            request address and store data
//   rsp_valid/rsp_data/rsp_err    response pulse, data (held), error flag
//   ram_addr/ram_wdata            registered RAM address and write data
//   ram_wren/ram_rden/ram_q       RAM strobes and read data
//   io_addr/io_wdata/io_wr/io_rd  MMIO offset, data, strobes
//   io_rdata                      MMIO read data (valid the cycle after io_rd)
// Optional feature macro: MEM_RESP_MMIO_EN enables the MMIO window; without
// it the window decodes as illegal and all io_* outputs are held at 0.
module mem_port_responder
   import cpu_mem_pkg::*;
#(
   parameter int                DATA_W    = CPU_DATA_W,
   parameter int                ADDR_W    = CPU_ADDR_W,
   parameter int                RAM_AW    = 10,
   parameter int                RD_LAT    = 2,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFF00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_ifetch,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   output logic [7:0]        io_addr,
   output logic              io_wr,
   output logic              io_rd,
   output logic [DATA_W-1:0] io_wdata,
   input  logic [DATA_W-1:0] io_rdata
);

   state_t      state;
   logic [1:0]  cnt;
   region_t     region_d;
   region_t     acc_region;
   logic        acc_write;
   logic        accept;

   mem_addr_decode #(
      .ADDR_W    (ADDR_W),
      .RAM_AW    (RAM_AW),
      .MMIO_BASE (MMIO_BASE)
   ) u_decode (
      .addr   (req_addr),
      .ifetch (req_ifetch),
      .region (region_d)
   );

   // RSP also accepts, so back-to-back requests lose no cycle.
   assign req_ready = (state == ST_IDLE) || (state == ST_RSP);
   assign accept    = req_valid && req_ready;

`ifdef MEM_RESP_MMIO_EN
   logic [DATA_W-1:0] io_hold;
`else
   logic unused_io;
   assign unused_io = ^io_rdata;
   assign io_addr   = '0;
   assign io_wr     = 1'b0;
   assign io_rd     = 1'b0;
   assign io_wdata  = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         acc_region <= REG_RAM;
         acc_write  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_wren   <= 1'b0;
         ram_rden   <= 1'b0;
`ifdef MEM_RESP_MMIO_EN
         io_hold    <= '0;
         io_addr    <= '0;
         io_wdata   <= '0;
         io_wr      <= 1'b0;
         io_rd      <= 1'b0;
`endif
      end else begin
         // Strobes and the response pulse last exactly one cycle.
         ram_wren  <= 1'b0;
         ram_rden  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
`ifdef MEM_RESP_MMIO_EN
         io_wr     <= 1'b0;
         io_rd     <= 1'b0;
`endif
         case (state)
            ST_IDLE: ;
            // RD_WAIT lasts RD_LAT cycles; ram_q is sampled when leaving RSP.
            ST_RD_WAIT: begin
               if (cnt == 2'(RD_LAT - 1))
                  state <= ST_RSP;
               else
                  cnt <= cnt + 2'd1;
            end
            ST_WR:  state <= ST_RSP;
            ST_ERR: state <= ST_RSP;
`ifdef MEM_RESP_MMIO_EN
            ST_IO:  state <= ST_IO_WAIT;
            ST_IO_WAIT: begin
               io_hold <= io_rdata;
               state   <= ST_RSP;
            end
`endif
            ST_RSP: begin
               rsp_valid <= 1'b1;
               rsp_err   <= (acc_region == REG_ERR);
               state     <= ST_IDLE;
               case (acc_region)
                  REG_ERR: rsp_data <= '0;
                  REG_RAM: if (!acc_write) rsp_data <= ram_q;
`ifdef MEM_RESP_MMIO_EN
                  REG_IO:  if (!acc_write) rsp_data <= io_hold;
`endif
                  default: ;
               endcase
            end
            default: state <= ST_IDLE;
         endcase

         // A new request overrides the RSP -> IDLE transition above.
         if (accept) begin
            acc_region <= region_d;
            acc_write  <= req_write;
            cnt        <= '0;
            case (region_d)
               REG_RAM: begin
                  ram_addr  <= req_addr[RAM_AW-1:0];
                  ram_wdata <= req_wdata;
                  ram_wren  <= req_write;
                  ram_rden  <= !req_write;
                  state     <= req_write ? ST_WR : ST_RD_WAIT;
               end
`ifdef MEM_RESP_MMIO_EN
               REG_IO: begin
                  io_addr  <= req_addr[7:0];
                  io_wdata <= req_wdata;
                  io_wr    <= req_write;
                  io_rd    <= !req_write;
                  state    <= ST_IO;
               end
`endif
               default: state <= ST_ERR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_port_responder.sv
module tb_mem_port_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_ifetch;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_data;
   logic [9:0]  ram_addr;
   logic [15:0] ram_wdata, ram_q;
   logic        ram_wren, ram_rden;
   logic [7:0]  io_addr;
   logic        io_wr, io_rd;
   logic [15:0] io_wdata, io_rdata;

   mem_port_responder dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_ifetch(req_ifetch), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
      .ram_rden(ram_rden), .ram_q(ram_q),
      .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
      .io_wdata(io_wdata), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   // Block RAM with a two-cycle read latency, plus an MMIO register source.
   logic [15:0] mem [0:1023];
   logic [15:0] ram_p1;
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      ram_p1   = 16'h0;
      ram_q    = 16'h0;
      io_rdata = 16'h0;
   end
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_p1 <= mem[ram_addr];
      ram_q    <= ram_p1;
      io_rdata <= io_rd ? 16'h1234 : 16'h0000;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          cyc;
      string       nm;
   } exp_t;
   exp_t sb[$];

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got data %0h err %0b expected no response (cycle %0d)",
                     rsp_data, rsp_err, cyc);
         end else begin
            e = sb.pop_front();
            chk({e.nm, "_data"},  rsp_data, e.data);
            chk({e.nm, "_err"},   rsp_err,  e.err);
            chk({e.nm, "_cycle"}, cyc,      e.cyc);
         end
      end
   end

   logic [15:0] last_data = 16'h0;

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input string nm, input logic wr, input logic ifetch,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] edata, input logic eerr, input int lat,
                        output int acc);
      int n = 0;
      exp_t e;
      acc = -1;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         chk({nm, "_ready_timeout"}, req_ready, 1);
         return;
      end
      req_valid = 1'b1; req_write = wr; req_ifetch = ifetch;
      req_addr = addr;  req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      acc    = cyc;
      e.data = edata; e.err = eerr; e.cyc = acc + lat; e.nm = nm;
      sb.push_back(e);
      last_data = edata;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_outstanding", sb.size(), 0);
   endtask

   int a1, a2, dummy;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_ifetch = 1'b0;
      req_addr = 16'h0; req_wdata = 16'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_strobes", {ram_wren, ram_rden, io_wr, io_rd}, 4'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", req_ready, 1);
      chk("idle_strobes", {ram_wren, ram_rden, io_wr, io_rd, rsp_valid}, 5'b0);

      // Store then read back
      issue("st_0010", 1'b1, 1'b0, 16'h0010, 16'hBEEF, last_data, 1'b0, 2, dummy);
      chk("st_wren", ram_wren, 1);
      chk("st_addr", ram_addr, 10'h010);
      chk("st_wdata", ram_wdata, 16'hBEEF);
      issue("rd_0010", 1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 3, dummy);
      chk("rd_rden", ram_rden, 1);
      chk("rd_wren", ram_wren, 0);
      chk("rd_addr", ram_addr, 10'h010);

      // Back-to-back reads
      issue("st_0001", 1'b1, 1'b0, 16'h0001, 16'h0A01, last_data, 1'b0, 2, dummy);
      issue("st_0002", 1'b1, 1'b0, 16'h0002, 16'h0A02, last_data, 1'b0, 2, dummy);
      issue("rd_0001", 1'b0, 1'b0, 16'h0001, 16'h0, 16'h0A01, 1'b0, 3, a1);
      issue("rd_0002", 1'b0, 1'b0, 16'h0002, 16'h0, 16'h0A02, 1'b0, 3, a2);
      chk("b2b_accept_gap", a2 - a1, 3);
      drain();

      // Out-of-range accesses
      issue("st_0000", 1'b1, 1'b0, 16'h0000, 16'h1111, last_data, 1'b0, 2, dummy);
      issue("st_0400", 1'b1, 1'b0, 16'h0400, 16'hDEAD, 16'h0, 1'b1, 2, dummy);
      for (int i = 0; i < 2; i++) begin
         chk("err_st_no_strobe", {ram_wren, ram_rden}, 2'b0);
         @(negedge clk);
      end
      issue("rd_0400", 1'b0, 1'b0, 16'h0400, 16'h0, 16'h0, 1'b1, 2, dummy);
      for (int i = 0; i < 2; i++) begin
         chk("err_rd_no_strobe", {ram_wren, ram_rden}, 2'b0);
         @(negedge clk);
      end
      issue("rd_0000", 1'b0, 1'b0, 16'h0000, 16'h0, 16'h1111, 1'b0, 3, dummy);
      drain();

      // MMIO window
      issue("if_ff04", 1'b0, 1'b1, 16'hFF04, 16'h0, 16'h0, 1'b1, 2, dummy);
      chk("if_no_io_rd", io_rd, 0);
`ifdef MEM_RESP_MMIO_EN
      issue("io_ff04", 1'b0, 1'b0, 16'hFF04, 16'h0, 16'h1234, 1'b0, 3, dummy);
      chk("io_rd", io_rd, 1);
      chk("io_addr", io_addr, 8'h04);
      chk("io_no_ram", {ram_wren, ram_rden}, 2'b0);
`else
      issue("io_ff04", 1'b0, 1'b0, 16'hFF04, 16'h0, 16'h0, 1'b1, 2, dummy);
      chk("io_off_rd", io_rd, 0);
      chk("io_off_no_ram", {ram_wren, ram_rden}, 2'b0);
`endif
      drain();

      // Reset between accept and the RAM write
      req_valid = 1'b1; req_write = 1'b1; req_ifetch = 1'b0;
      req_addr = 16'h0020; req_wdata = 16'h5555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rstw_wren_pending", ram_wren, 1);
      reset = 1'b1;
      #1;
      chk("rstw_wren_cleared", ram_wren, 0);
      chk("rstw_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      last_data = 16'h0;
      chk("rstw_ready", req_ready, 1);
      chk("rstw_rsp_data", rsp_data, 16'h0);
      repeat (4) @(negedge clk);
      chk("rstw_mem_untouched", mem[10'h020], 16'h0);
      issue("rd_0020", 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0, 1'b0, 3, dummy);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute bound on the run.
   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
